// File: rtl/sine_pkg.sv
// Shared types and widths for the sine sweep sequencer.
//   XW / RW  : argument (Q0.16) and sineTop result widths
//   state_e  : sequencer FSM states
//   result_t : one buffered (x, sin x) pair
package sine_pkg;

  localparam int unsigned XW     = 16;
  localparam int unsigned RW     = 18;
  localparam int unsigned EntryW = XW + RW;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFin
  } state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [RW-1:0] r;
  } result_t;

endpackage

// File: rtl/sweep_fifo.sv
// Synchronous show-ahead FIFO for sweep results.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   valid_o      : FIFO non-empty
//   head_o       : head entry, valid whenever valid_o is high
//   level_o      : number of stored entries, 0..DEPTH
module sweep_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (level_q != DepthLvl);
  assign do_pop  = pop_i && (level_q != '0);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign valid_o = (level_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Drives a sineTop unit across an arithmetic sweep of arguments and buffers
// each (x, sin x) pair in a show-ahead FIFO drained by a valid/ready stream.
//   clk, rst              : clock, asynchronous active-high reset
//   go_i, abort_i         : start / cancel a sweep (pulses)
//   x_start_i, x_step_i   : first argument and increment, unsigned Q0.16
//   x_count_i             : number of evaluations
//   busy_o, sweep_done_o  : sweep in progress / one-cycle end pulse
//   sin_start_o, sin_x_bus_o, sin_r_bus_i, sin_done_i : sineTop handshake
//   out_valid_o, out_ready_i, out_x_o, out_r_o        : result stream
module sine_sweep_ctrl
  import sine_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go_i,
  input  logic            abort_i,
  input  logic [XW-1:0]   x_start_i,
  input  logic [XW-1:0]   x_step_i,
  input  logic [CNTW-1:0] x_count_i,
  output logic            busy_o,
  output logic            sweep_done_o,
  output logic            sin_start_o,
  output logic [XW-1:0]   sin_x_bus_o,
  input  logic [RW-1:0]   sin_r_bus_i,
  input  logic            sin_done_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XW-1:0]   out_x_o,
  output logic [RW-1:0]   out_r_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);

  state_e          state_q;
  logic [XW-1:0]   cur_x_q, step_q, sin_x_q;
  logic [CNTW-1:0] remaining_q;
  logic            sin_start_q, sweep_done_q, busy_q, sin_done_q;

  logic            done_rise;
  logic            push;
  logic            fifo_room;
  logic [LW-1:0]   fifo_level;
  result_t         push_entry, head_entry;
  logic [EntryW-1:0] head_raw;

  // Only a rising edge counts, so a level-held done is never re-accepted.
  assign done_rise = sin_done_i && !sin_done_q;
  assign fifo_room = (fifo_level < DepthLvl);

  // A done edge coinciding with abort is dropped.
  assign push       = (state_q == StWait) && done_rise && !abort_i;
  assign push_entry = '{x: cur_x_q, r: sin_r_bus_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_x_q      <= '0;
      step_q       <= '0;
      remaining_q  <= '0;
      sin_x_q      <= '0;
      sin_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
      sin_done_q   <= 1'b0;
    end else begin
      sin_done_q   <= sin_done_i;
      sin_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      if ((state_q != StIdle) && abort_i) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (go_i) begin
              cur_x_q     <= x_start_i;
              step_q      <= x_step_i;
              remaining_q <= x_count_i;
              busy_q      <= 1'b1;
              state_q     <= (x_count_i != '0) ? StIssue : StFin;
            end
          end
          StIssue: begin
            // Stall here while the FIFO is full.
            if (fifo_room) begin
              sin_start_q <= 1'b1;
              sin_x_q     <= cur_x_q;
              state_q     <= StWait;
            end
          end
          StWait: begin
            if (done_rise) begin
              cur_x_q     <= cur_x_q + step_q;
              remaining_q <= remaining_q - 1'b1;
              state_q     <= (remaining_q == CNTW'(1)) ? StFin : StIssue;
            end
          end
          StFin: begin
            sweep_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  sweep_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (out_ready_i),
    .valid_o     (out_valid_o),
    .head_o      (head_raw),
    .level_o     (fifo_level)
  );

  assign head_entry   = result_t'(head_raw);
  assign out_x_o      = head_entry.x;
  assign out_r_o      = head_entry.r;

  assign busy_o       = busy_q;
  assign sweep_done_o = sweep_done_q;
  assign sin_start_o  = sin_start_q;
  assign sin_x_bus_o  = sin_x_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Self-checking bench for sine_sweep_ctrl with a behavioural sineTop model
// of configurable latency and pulse/level done behaviour.
module tb_sine_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go, abort_s;
  logic [15:0] x_start, x_step;
  logic [7:0]  x_count;
  logic        busy, sweep_done, sin_start;
  logic [15:0] sin_x_bus;
  logic [17:0] sin_r_bus;
  logic        sin_done;
  logic        out_valid, out_ready;
  logic [15:0] out_x;
  logic [17:0] out_r;

  int pass_cnt = 0;
  int total_cnt = 0;
  int starts = 0;
  int dones = 0;

  logic [15:0] exp_x_q [$];
  logic [33:0] exp_out_q [$];

  always #5 clk = ~clk;

  sine_sweep_ctrl #(
    .DEPTH (4),
    .CNTW  (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .go_i         (go),
    .abort_i      (abort_s),
    .x_start_i    (x_start),
    .x_step_i     (x_step),
    .x_count_i    (x_count),
    .busy_o       (busy),
    .sweep_done_o (sweep_done),
    .sin_start_o  (sin_start),
    .sin_x_bus_o  (sin_x_bus),
    .sin_r_bus_i  (sin_r_bus),
    .sin_done_i   (sin_done),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_x_o      (out_x),
    .out_r_o      (out_r)
  );

  // Stand-in for sineTop: any fixed function of x distinguishes entries.
  function automatic logic [17:0] model_r(input logic [15:0] x);
    return {x[1:0], x ^ 16'h5A3C};
  endfunction

  int          lat_cfg = 3;
  bit          level_mode = 0;
  int          m_cnt;
  bit          m_active;
  logic [15:0] m_x;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_done  <= 1'b0;
      sin_r_bus <= '0;
      m_active  <= 1'b0;
      m_cnt     <= 0;
      m_x       <= '0;
    end else if (sin_start) begin
      m_active <= 1'b1;
      m_cnt    <= lat_cfg;
      m_x      <= sin_x_bus;
      sin_done <= 1'b0;
    end else if (m_active) begin
      if (m_cnt <= 1) begin
        sin_done  <= 1'b1;
        sin_r_bus <= model_r(m_x);
        m_active  <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (!level_mode) begin
      sin_done <= 1'b0;
    end
  end

  // Scoreboard: issued arguments and stream output against expectations.
  logic [15:0] mon_x;
  logic [33:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (sin_start) begin
        starts++;
        total_cnt++;
        if (exp_x_q.size() == 0) begin
          $display("FAIL sin_start_unexpected: sinXBus=%h, no start expected", sin_x_bus);
        end else begin
          mon_x = exp_x_q.pop_front();
          if (sin_x_bus !== mon_x)
            $display("FAIL sin_x_bus: got %h expected %h", sin_x_bus, mon_x);
          else
            pass_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        total_cnt++;
        if (exp_out_q.size() == 0) begin
          $display("FAIL out_unexpected: outX=%h outR=%h, no entry expected", out_x, out_r);
        end else begin
          mon_e = exp_out_q.pop_front();
          if ({out_x, out_r} !== mon_e)
            $display("FAIL out_entry: got x=%h r=%h expected x=%h r=%h",
                     out_x, out_r, mon_e[33:18], mon_e[17:0]);
          else
            pass_cnt++;
        end
      end
      if (sweep_done) dones++;
    end
  end

  task automatic pulse_go(input logic [15:0] xs, input logic [15:0] st, input logic [7:0] n);
    @(negedge clk);
    x_start = xs;
    x_step  = st;
    x_count = n;
    go      = 1'b1;
    @(negedge clk);
    go      = 1'b0;
  endtask

  task automatic launch(input logic [15:0] xs, input logic [15:0] st, input logic [7:0] n);
    logic [15:0] x;
    x = xs;
    for (int i = 0; i < int'(n); i++) begin
      exp_x_q.push_back(x);
      exp_out_q.push_back({x, model_r(x)});
      x = x + st;
    end
    pulse_go(xs, st, n);
  endtask

  task automatic wait_sweep_done(input int budget, input string name);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (sweep_done) seen = 1;
    end
    total_cnt++;
    if (seen) pass_cnt++;
    else $display("FAIL %s_timeout: sweepDone not seen in %0d cycles, expected a pulse", name, budget);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total_cnt++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d", name, got, want);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; abort_s = 1'b0; out_ready = 1'b0;
    x_start = '0; x_step = '0; x_count = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, sweep_done, sin_start, sin_x_bus, out_valid, out_x, out_r} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b start=%b x=%h valid=%b ox=%h or=%h expected all 0",
               busy, sweep_done, sin_start, sin_x_bus, out_valid, out_x, out_r);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0 0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int s0 = starts, d0 = dones;
    out_ready = 1'b1; lat_cfg = 3;
    launch(16'h1000, 16'h0800, 8'd3);
    wait_sweep_done(200, "basic");
    repeat (4) @(negedge clk);
    check_int("basic_starts", starts - s0, 3);
    check_int("basic_dones", dones - d0, 1);
    check_int("basic_left", exp_out_q.size(), 0);
  endtask

  task automatic test_wrap();
    int s0 = starts;
    out_ready = 1'b1; lat_cfg = 1;
    launch(16'hF000, 16'h1000, 8'd2);
    wait_sweep_done(200, "wrap");
    repeat (4) @(negedge clk);
    check_int("wrap_starts", starts - s0, 2);
    check_int("wrap_left", exp_out_q.size(), 0);
  endtask

  task automatic test_back_pressure();
    int s0 = starts;
    out_ready = 1'b0; lat_cfg = 2;
    launch(16'h0100, 16'h0111, 8'd6);
    repeat (60) @(negedge clk);
    check_int("bp_stall_starts", starts - s0, 4);
    check_int("bp_level", int'(u_dut.u_fifo.level_o), 4);
    total_cnt++;
    if (busy !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL bp_stalled: got busy=%b valid=%b expected 1 1", busy, out_valid);
    else pass_cnt++;
    out_ready = 1'b1;
    wait_sweep_done(200, "bp");
    repeat (4) @(negedge clk);
    check_int("bp_total_starts", starts - s0, 6);
    check_int("bp_left", exp_out_q.size(), 0);
  endtask

  task automatic test_zero_busy();
    int s0 = starts;
    out_ready = 1'b1; lat_cfg = 4;
    @(negedge clk);
    x_start = 16'h2222; x_step = 16'h0001; x_count = 8'd0; go = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (sweep_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_edge_k: got done=%b busy=%b expected 0 1", sweep_done, busy);
    else pass_cnt++;
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (sweep_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_edge_k1: got done=%b busy=%b expected 1 0", sweep_done, busy);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_int("zero_starts", starts - s0, 0);
    // Second go mid-sweep must change nothing.
    s0 = starts;
    launch(16'h3000, 16'h0010, 8'd3);
    repeat (3) @(negedge clk);
    pulse_go(16'h7777, 16'h0001, 8'd5);
    wait_sweep_done(200, "busy_go");
    repeat (10) @(negedge clk);
    check_int("busy_go_starts", starts - s0, 3);
    check_int("busy_go_left", exp_out_q.size(), 0);
  endtask

  task automatic test_level_done();
    int s0 = starts;
    out_ready = 1'b1; lat_cfg = 2; level_mode = 1;
    launch(16'h4000, 16'h0123, 8'd3);
    wait_sweep_done(200, "level");
    repeat (10) @(negedge clk);
    check_int("level_starts", starts - s0, 3);
    check_int("level_left", exp_out_q.size(), 0);
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL level_no_repush: got outValid=%b expected 0", out_valid);
    else pass_cnt++;
    level_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int s0 = starts, d0 = dones;
    int n = 0;
    out_ready = 1'b0; lat_cfg = 6;
    launch(16'h5000, 16'h0200, 8'd4);
    while (starts - s0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int("abort_reach_second_start", starts - s0, 2);
    // Now in WAIT for the second argument; only the first result is kept.
    exp_x_q.delete();
    while (exp_out_q.size() > 1) void'(exp_out_q.pop_back());
    abort_s = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b1 || out_x !== 16'h5000)
      $display("FAIL abort_next: got busy=%b valid=%b outX=%h expected 0 1 5000",
               busy, out_valid, out_x);
    else pass_cnt++;
    @(negedge clk);
    abort_s = 1'b0;
    repeat (15) @(negedge clk);
    check_int("abort_level", int'(u_dut.u_fifo.level_o), 1);
    check_int("abort_no_done", dones - d0, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_int("abort_left", exp_out_q.size(), 0);
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL abort_drained: got outValid=%b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; lat_cfg = 2;
    launch(16'h6000, 16'h0040, 8'd5);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, sweep_done, sin_start, sin_x_bus, out_valid, out_x, out_r} !== '0)
      $display("FAIL reset_async: got busy=%b done=%b start=%b x=%h valid=%b ox=%h or=%h expected all 0",
               busy, sweep_done, sin_start, sin_x_bus, out_valid, out_x, out_r);
    else pass_cnt++;
    exp_x_q.delete();
    exp_out_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_pressure();
    test_zero_busy();
    test_level_done();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
